// File: rtl/triangle_setup.sv
// Triangle setup: edge-function coefficients, signed area, culling and a
// screen-clamped bounding box, handed to the bbox iterator one triangle at a time.
module triangle_setup #(
   parameter int XLEN     = 15,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic signed [XLEN:0]    i_x0,
   input  logic signed [XLEN:0]    i_y0,
   input  logic signed [XLEN:0]    i_x1,
   input  logic signed [XLEN:0]    i_y1,
   input  logic signed [XLEN:0]    i_x2,
   input  logic signed [XLEN:0]    i_y2,
   input  logic                    i_raster_done,
   output logic                    o_bb_write,
   output logic signed [XLEN:0]    o_bbx0,
   output logic signed [XLEN:0]    o_bbx1,
   output logic signed [XLEN:0]    o_bby0,
   output logic signed [XLEN:0]    o_bby1,
   output logic [3*(XLEN+2)-1:0]   o_a,
   output logic [3*(XLEN+2)-1:0]   o_b,
   output logic [3*(2*XLEN+3)-1:0] o_c,
   output logic                    o_culled
);
   localparam int VW = XLEN + 1;
   localparam int AW = XLEN + 2;
   localparam int CW = 2 * XLEN + 3;
   localparam int RW = 2 * XLEN + 5;
   localparam int PW = 2 * VW;
   localparam logic signed [VW-1:0] XMAX = VW'(SCREEN_W - 1);
   localparam logic signed [VW-1:0] YMAX = VW'(SCREEN_H - 1);

   typedef enum logic [2:0] {IDLE, E0, E1, E2, AREA, DECIDE, WAIT} state_t;
   state_t state, state_nxt;

   logic signed [VW-1:0] vx [3];
   logic signed [VW-1:0] vy [3];
   logic signed [AW-1:0] a_r [3];
   logic signed [AW-1:0] b_r [3];
   logic signed [CW-1:0] c_r [3];
   logic signed [RW-1:0] area;
   logic [1:0]           sel;
   logic signed [VW-1:0] xa, ya, xb, yb;
   logic signed [AW-1:0] a_new, b_new;
   logic signed [PW-1:0] p_ab, p_ba;
   logic signed [CW-1:0] c_new;
   logic signed [VW-1:0] min_x, max_x, min_y, max_y;
   logic                 transfer, cull;

   function automatic logic signed [VW-1:0] min3(input logic signed [VW-1:0] p, q, r);
      logic signed [VW-1:0] m;
      m = (p < q) ? p : q;
      return (r < m) ? r : m;
   endfunction

   function automatic logic signed [VW-1:0] max3(input logic signed [VW-1:0] p, q, r);
      logic signed [VW-1:0] m;
      m = (p > q) ? p : q;
      return (r > m) ? r : m;
   endfunction

   // The cull pulse cycle still counts as busy, so a culled triangle costs 7 cycles
   assign o_ready  = (state == IDLE) && !o_culled;
   assign transfer = i_valid && o_ready;
   assign cull     = (area == '0) || (o_bbx0 > o_bbx1) || (o_bby0 > o_bby1);

   // One shared multiplier pair walks the three edges in E0, E1, E2
   always_comb begin
      sel = 2'd0;
      xa  = vx[0];
      ya  = vy[0];
      xb  = vx[1];
      yb  = vy[1];
      case (state)
         E1: begin
            sel = 2'd1;
            xa  = vx[1];
            ya  = vy[1];
            xb  = vx[2];
            yb  = vy[2];
         end
         E2: begin
            sel = 2'd2;
            xa  = vx[2];
            ya  = vy[2];
            xb  = vx[0];
            yb  = vy[0];
         end
         default: ;
      endcase
      a_new = AW'(ya) - AW'(yb);
      b_new = AW'(xb) - AW'(xa);
      p_ab  = PW'(xa) * PW'(yb);
      p_ba  = PW'(xb) * PW'(ya);
      c_new = CW'(p_ab) - CW'(p_ba);
   end

   always_comb begin
      min_x = min3(vx[0], vx[1], vx[2]);
      max_x = max3(vx[0], vx[1], vx[2]);
      min_y = min3(vy[0], vy[1], vy[2]);
      max_y = max3(vy[0], vy[1], vy[2]);
      if (min_x < 0)    min_x = '0;
      if (max_x > XMAX) max_x = XMAX;
      if (min_y < 0)    min_y = '0;
      if (max_y > YMAX) max_y = YMAX;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (transfer) state_nxt = E0;
         E0:      state_nxt = E1;
         E1:      state_nxt = E2;
         E2:      state_nxt = AREA;
         AREA:    state_nxt = DECIDE;
         DECIDE:  state_nxt = cull ? IDLE : WAIT;
         WAIT:    if (i_raster_done && !o_bb_write) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < 3; i++) begin
            vx[i]  <= '0;
            vy[i]  <= '0;
            a_r[i] <= '0;
            b_r[i] <= '0;
            c_r[i] <= '0;
         end
         area       <= '0;
         o_bbx0     <= '0;
         o_bbx1     <= '0;
         o_bby0     <= '0;
         o_bby1     <= '0;
         o_bb_write <= 1'b0;
         o_culled   <= 1'b0;
      end else begin
         o_bb_write <= 1'b0;
         o_culled   <= 1'b0;
         case (state)
            IDLE: if (transfer) begin
               vx[0] <= i_x0;
               vy[0] <= i_y0;
               vx[1] <= i_x1;
               vy[1] <= i_y1;
               vx[2] <= i_x2;
               vy[2] <= i_y2;
            end
            E0, E1, E2: begin
               for (int i = 0; i < 3; i++) begin
                  if (sel == 2'(i)) begin
                     a_r[i] <= a_new;
                     b_r[i] <= b_new;
                     c_r[i] <= c_new;
                  end
               end
               if (state == E0) begin
                  o_bbx0 <= min_x;
                  o_bbx1 <= max_x;
                  o_bby0 <= min_y;
                  o_bby1 <= max_y;
               end
            end
            AREA: area <= RW'(c_r[0]) + RW'(c_r[1]) + RW'(c_r[2]);
            // Clockwise triangles are flipped so inside is always edge >= 0
            DECIDE: begin
               if (cull) begin
                  o_culled <= 1'b1;
               end else begin
                  if (area < 0) begin
                     for (int i = 0; i < 3; i++) begin
                        a_r[i] <= -a_r[i];
                        b_r[i] <= -b_r[i];
                        c_r[i] <= -c_r[i];
                     end
                  end
                  o_bb_write <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      o_a = '0;
      o_b = '0;
      o_c = '0;
      for (int i = 0; i < 3; i++) begin
         o_a[i*AW +: AW] = a_r[i];
         o_b[i*AW +: AW] = b_r[i];
         o_c[i*CW +: CW] = c_r[i];
      end
   end
endmodule

// File: tb/tb_triangle_setup.sv
// Bench for triangle_setup: hand-derived vector table, reset/handshake sequences,
// and random triangles against a wide-integer reference model.
module tb_triangle_setup;
   localparam int AW = 17;
   localparam int CW = 33;
   localparam int SW = 640;
   localparam int SH = 480;

   logic               i_clk;
   logic               i_reset_n;
   logic               i_valid;
   logic               o_ready;
   logic signed [15:0] i_x0, i_y0, i_x1, i_y1, i_x2, i_y2;
   logic               i_raster_done;
   logic               o_bb_write;
   logic signed [15:0] o_bbx0, o_bbx1, o_bby0, o_bby1;
   logic [3*AW-1:0]    o_a, o_b;
   logic [3*CW-1:0]    o_c;
   logic               o_culled;

   int errors = 0;
   int checks = 0;

   typedef struct {
      longint x0, y0, x1, y1, x2, y2;
      bit     cull;
      longint bx0, bx1, by0, by1;
      longint a0, a1, a2, b0, b1, b2, c0, c1, c2;
   } vec_t;

   vec_t vecs [7];

   triangle_setup #(.XLEN(15), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_x0(i_x0), .i_y0(i_y0), .i_x1(i_x1), .i_y1(i_y1), .i_x2(i_x2), .i_y2(i_y2),
      .i_raster_done(i_raster_done), .o_bb_write(o_bb_write),
      .o_bbx0(o_bbx0), .o_bbx1(o_bbx1), .o_bby0(o_bby0), .o_bby1(o_bby1),
      .o_a(o_a), .o_b(o_b), .o_c(o_c), .o_culled(o_culled)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic longint getA(input int i);
      logic signed [AW-1:0] t;
      t = o_a[i*AW +: AW];
      return longint'(t);
   endfunction

   function automatic longint getB(input int i);
      logic signed [AW-1:0] t;
      t = o_b[i*AW +: AW];
      return longint'(t);
   endfunction

   function automatic longint getC(input int i);
      logic signed [CW-1:0] t;
      t = o_c[i*CW +: CW];
      return longint'(t);
   endfunction

   function automatic vec_t mkVec(input longint x0, y0, x1, y1, x2, y2, input bit cull,
                                  input longint bx0, bx1, by0, by1,
                                  input longint a0, a1, a2, b0, b1, b2, c0, c1, c2);
      vec_t v;
      v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1; v.x2 = x2; v.y2 = y2;
      v.cull = cull;
      v.bx0 = bx0; v.bx1 = bx1; v.by0 = by0; v.by1 = by1;
      v.a0 = a0; v.a1 = a1; v.a2 = a2;
      v.b0 = b0; v.b1 = b1; v.b2 = b2;
      v.c0 = c0; v.c1 = c1; v.c2 = c2;
      return v;
   endfunction

   // Reference: edge functions straight from the vertex math, 64-bit wide
   function automatic vec_t model(input longint x0, y0, x1, y1, x2, y2);
      longint xs [3];
      longint ys [3];
      longint a [3];
      longint b [3];
      longint c [3];
      longint area, lx, hx, ly, hy;
      int     j;
      bit     cull;
      xs[0] = x0; xs[1] = x1; xs[2] = x2;
      ys[0] = y0; ys[1] = y1; ys[2] = y2;
      area = 0;
      lx = xs[0]; hx = xs[0]; ly = ys[0]; hy = ys[0];
      for (int i = 0; i < 3; i++) begin
         j = (i + 1) % 3;
         a[i] = ys[i] - ys[j];
         b[i] = xs[j] - xs[i];
         c[i] = xs[i] * ys[j] - xs[j] * ys[i];
         area += c[i];
         if (xs[i] < lx) lx = xs[i];
         if (xs[i] > hx) hx = xs[i];
         if (ys[i] < ly) ly = ys[i];
         if (ys[i] > hy) hy = ys[i];
      end
      if (lx < 0) lx = 0;
      if (ly < 0) ly = 0;
      if (hx > SW - 1) hx = SW - 1;
      if (hy > SH - 1) hy = SH - 1;
      cull = (area == 0) || (lx > hx) || (ly > hy);
      if (area < 0) begin
         for (int i = 0; i < 3; i++) begin
            a[i] = -a[i];
            b[i] = -b[i];
            c[i] = -c[i];
         end
      end
      return mkVec(x0, y0, x1, y1, x2, y2, cull, lx, hx, ly, hy,
                   a[0], a[1], a[2], b[0], b[1], b[2], c[0], c[1], c[2]);
   endfunction

   task automatic checkOutput(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic checkAll(input vec_t v, input string n);
      longint ea [3];
      longint eb [3];
      longint ec [3];
      ea[0] = v.a0; ea[1] = v.a1; ea[2] = v.a2;
      eb[0] = v.b0; eb[1] = v.b1; eb[2] = v.b2;
      ec[0] = v.c0; ec[1] = v.c1; ec[2] = v.c2;
      checkOutput({n, " bbx0"}, longint'(o_bbx0), v.bx0);
      checkOutput({n, " bbx1"}, longint'(o_bbx1), v.bx1);
      checkOutput({n, " bby0"}, longint'(o_bby0), v.by0);
      checkOutput({n, " bby1"}, longint'(o_bby1), v.by1);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("%s a%0d", n, i), getA(i), ea[i]);
         checkOutput($sformatf("%s b%0d", n, i), getB(i), eb[i]);
         checkOutput($sformatf("%s c%0d", n, i), getC(i), ec[i]);
      end
   endtask

   task automatic scramble();
      i_x0 = 16'($urandom); i_y0 = 16'($urandom);
      i_x1 = 16'($urandom); i_y1 = 16'($urandom);
      i_x2 = 16'($urandom); i_y2 = 16'($urandom);
   endtask

   task automatic applyStimulus(input vec_t v, input string n);
      int j;
      j = 0;
      while (!o_ready && j < 20) begin
         @(posedge i_clk); #1;
         j++;
      end
      checkOutput({n, " ready before transfer"}, longint'(o_ready), 1);
      i_valid = 1'b1;
      i_x0 = 16'(v.x0); i_y0 = 16'(v.y0);
      i_x1 = 16'(v.x1); i_y1 = 16'(v.y1);
      i_x2 = 16'(v.x2); i_y2 = 16'(v.y2);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      scramble();
      j = 0;
      while (!(o_bb_write || o_culled) && j < 12) begin
         @(posedge i_clk); #1;
         j++;
      end
      checkOutput({n, " strobe latency"}, j, 5);
      checkOutput({n, " strobe exclusive"}, longint'(o_bb_write & o_culled), 0);
      checkOutput({n, " bb_write"}, longint'(o_bb_write), longint'(!v.cull));
      checkOutput({n, " culled"}, longint'(o_culled), longint'(v.cull));
      if (o_bb_write) begin
         checkAll(v, n);
         i_raster_done = 1'b1;
         @(posedge i_clk); #1;
         i_raster_done = 1'b0;
         checkOutput({n, " bb_write one cycle"}, longint'(o_bb_write), 0);
         checkOutput({n, " done ignored in strobe cycle"}, longint'(o_ready), 0);
         i_valid = 1'b1;
         j = int'($urandom_range(0, 3));
         for (int k = 0; k < j; k++) begin
            @(posedge i_clk); #1;
            scramble();
         end
         checkOutput({n, " ready in wait"}, longint'(o_ready), 0);
         checkAll(v, {n, " held"});
         i_raster_done = 1'b1;
         @(posedge i_clk); #1;
         i_raster_done = 1'b0;
         i_valid = 1'b0;
         checkOutput({n, " ready after done"}, longint'(o_ready), 1);
      end else if (o_culled) begin
         @(posedge i_clk); #1;
         checkOutput({n, " cull one cycle"}, longint'(o_culled), 0);
         checkOutput({n, " ready after cull"}, longint'(o_ready), 1);
      end
   endtask

   initial begin
      int strobes;
      longint ev;
      vec_t r;
      longint cx [3];
      longint cy [3];
      int mode;

      i_reset_n = 1'b0;
      i_valid = 1'b0;
      i_raster_done = 1'b0;
      i_x0 = '0; i_y0 = '0; i_x1 = '0; i_y1 = '0; i_x2 = '0; i_y2 = '0;

      vecs[0] = mkVec(10, 10, 20, 10, 10, 20, 0, 10, 20, 10, 20,
                      0, -10, 10, 10, -10, 0, -100, 300, -100);
      vecs[1] = mkVec(10, 10, 10, 20, 20, 10, 0, 10, 20, 10, 20,
                      10, -10, 0, 0, -10, 10, -100, 300, -100);
      vecs[2] = mkVec(0, 0, 5, 5, 10, 10, 1, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[3] = mkVec(-5, -5, 700, 0, 0, 500, 0, 0, 639, 0, 479,
                      -5, -500, 505, 705, -700, -5, 3500, 350000, 2500);
      vecs[4] = mkVec(-50, -50, -10, -50, -50, -10, 1, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[5] = mkVec(700, 10, 800, 10, 700, 100, 1, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[6] = mkVec(-32768, -32768, 32767, -32768, -32768, 32767, 0, 0, 639, 0, 479,
                      0, -65535, 65535, 65535, -65535, 0,
                      2147450880, -65535, 2147450880);

      repeat (3) @(posedge i_clk);
      #1;
      checkOutput("reset bb_write", longint'(o_bb_write), 0);
      checkOutput("reset culled", longint'(o_culled), 0);
      checkOutput("reset a", longint'(o_a), 0);
      checkOutput("reset bbx1", longint'(o_bbx1), 0);
      i_reset_n = 1'b1;
      @(posedge i_clk); #1;
      checkOutput("ready after reset", longint'(o_ready), 1);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
         if (i == 1) begin
            for (int e = 0; e < 3; e++) begin
               ev = getA(e) * 12 + getB(e) * 12 + getC(e);
               checkOutput($sformatf("vec1 inside edge%0d at 12,12", e), longint'(ev >= 0), 1);
            end
         end
      end

      // Reset arriving mid-computation (state E1) must drop the triangle silently
      i_valid = 1'b1;
      i_x0 = 16'(10); i_y0 = 16'(10); i_x1 = 16'(20); i_y1 = 16'(10);
      i_x2 = 16'(10); i_y2 = 16'(20);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      @(posedge i_clk); #1;
      i_reset_n = 1'b0;
      #1;
      checkOutput("midreset bb_write", longint'(o_bb_write), 0);
      checkOutput("midreset culled", longint'(o_culled), 0);
      checkOutput("midreset a", longint'(o_a), 0);
      checkOutput("midreset b", longint'(o_b), 0);
      checkOutput("midreset c nonzero", longint'(|o_c), 0);
      checkOutput("midreset bbx1", longint'(o_bbx1), 0);
      checkOutput("midreset bby1", longint'(o_bby1), 0);
      @(posedge i_clk); #1;
      i_reset_n = 1'b1;
      strobes = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge i_clk); #1;
         if (o_bb_write || o_culled) strobes++;
      end
      checkOutput("midreset strobes", strobes, 0);
      checkOutput("midreset ready", longint'(o_ready), 1);

      for (int t = 0; t < 60; t++) begin
         mode = int'($urandom_range(0, 3));
         for (int i = 0; i < 3; i++) begin
            case (mode)
               0: begin
                  cx[i] = longint'($urandom_range(0, 800)) - 80;
                  cy[i] = longint'($urandom_range(0, 600)) - 60;
               end
               1: begin
                  cx[i] = longint'($signed(16'($urandom)));
                  cy[i] = longint'($signed(16'($urandom)));
               end
               default: begin
                  cx[i] = longint'($urandom_range(0, 60)) - 20;
                  cy[i] = longint'($urandom_range(0, 60)) - 20;
               end
            endcase
         end
         if (mode == 3) begin
            cx[2] = cx[1];
            cy[2] = cy[1];
         end
         r = model(cx[0], cy[0], cx[1], cy[1], cx[2], cy[2]);
         applyStimulus(r, $sformatf("rand%0d", t));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
